// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU datapath types.
// Holds the multiply/divide op codes and the muldiv FSM states.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: signal bundle for muldiv_unit.
// The md modport is the unit side and the tb modport is the bench side.
interface muldiv_if
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input logic CLK
);
    logic             nRST;
    logic             start;
    logic             flush;
    muldiv_op_t       op;
    logic [WIDTH-1:0] port_a;
    logic [WIDTH-1:0] port_b;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport md (
        input  CLK, nRST, start, flush, op, port_a, port_b,
        output busy, done, dz, hi, lo
    );

    modport tb (
        input  CLK, busy, done, dz, hi, lo,
        output nRST, start, flush, op, port_a, port_b
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide that writes its results to HI/LO.
// Define MULDIV_DIV_EN to build the divider datapath; otherwise DIV/DIVU finish as no-ops.
module muldiv_unit
    import cpu_types_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             start,
    input  logic             flush,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] port_a,
    input  logic [WIDTH-1:0] port_b,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef logic [2*WIDTH:0] acc_t;
    typedef logic [WIDTH-1:0] word_t;

    muldiv_state_t           state_q, state_d;
    logic [CW-1:0]           cnt_q;
    acc_t                    acc_q, mul_next;
    word_t                   b_q;
    logic                    is_div_q, neg_q;
    logic signed [WIDTH-1:0] a_s, b_s;
    logic                    sgn_op, a_neg, b_neg, accept;
    logic [WIDTH:0]          mul_sum;
    logic [2*WIDTH-1:0]      prod;
    word_t                   fix_hi, fix_lo;
    logic                    fix_dz, fix_wr;

    function automatic word_t mag(input word_t v, input logic neg);
        return neg ? -v : v;
    endfunction

    assign a_s    = port_a;
    assign b_s    = port_b;
    assign sgn_op = ~op[0];
    assign a_neg  = sgn_op && (a_s < 0);
    assign b_neg  = sgn_op && (b_s < 0);
    assign accept = (state_q == IDLE) && start && !flush;

`ifdef MULDIV_DIV_EN
    word_t          a_q;
    logic           neg_r_q, dz_q;
    acc_t           div_shift, div_next;
    logic [WIDTH:0] div_trial;

    // Restoring step: accumulator is {remainder[W:0], quotient[W-1:0]}.
    always_comb begin
        div_shift = {acc_q[2*WIDTH-1:0], 1'b0};
        div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, b_q};
        div_next  = div_trial[WIDTH] ? div_shift
                                     : {div_trial, div_shift[WIDTH-1:1], 1'b1};
    end
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef MULDIV_DIV_EN
                    state_d = (op[1] && port_b == '0) ? FIX : CALC;
`else
                    state_d = op[1] ? FIX : CALC;
`endif
                end
            end
            CALC: begin
                if (flush)
                    state_d = IDLE;
                else if (cnt_q == CW'(1))
                    state_d = FIX;
            end
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Shift-add step: multiplier sits in the low half and is consumed LSB first.
    always_comb begin
        mul_sum  = acc_q[2*WIDTH:WIDTH] + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
        prod     = neg_q ? -acc_q[2*WIDTH-1:0] : acc_q[2*WIDTH-1:0];
        fix_hi   = prod[2*WIDTH-1:WIDTH];
        fix_lo   = prod[WIDTH-1:0];
        fix_dz   = 1'b0;
        fix_wr   = !is_div_q;
`ifdef MULDIV_DIV_EN
        if (is_div_q) begin
            fix_wr = 1'b1;
            if (dz_q) begin
                fix_dz = 1'b1;
                fix_hi = a_q;
                fix_lo = '1;
            end else begin
                fix_lo = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                fix_hi = neg_r_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            end
        end
`endif
    end

    // Operand/accumulator registers carry no reset; they are always loaded on accept.
    always_ff @(posedge CLK) begin
        if (accept) begin
            acc_q    <= {{(WIDTH + 1){1'b0}}, mag(port_a, a_neg)};
            b_q      <= mag(port_b, b_neg);
            is_div_q <= op[1];
            neg_q    <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
            neg_r_q  <= a_neg;
            dz_q     <= (port_b == '0);
            a_q      <= port_a;
`endif
        end else if (state_q == CALC) begin
`ifdef MULDIV_DIV_EN
            acc_q <= is_div_q ? div_next : mul_next;
`else
            acc_q <= mul_next;
`endif
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            dz    <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                busy  <= 1'b1;
                cnt_q <= CW'(WIDTH);
            end else if (state_q == CALC) begin
                cnt_q <= cnt_q - CW'(1);
                if (flush)
                    busy <= 1'b0;
            end else if (state_q == FIX) begin
                busy <= 1'b0;
                if (!flush) begin
                    done <= 1'b1;
                    dz   <= fix_dz;
                    if (fix_wr) begin
                        hi <= fix_hi;
                        lo <= fix_lo;
                    end
                end
            end
        end
    end

endmodule
